// File: rtl/file_responder_if.sv
// Signal bundle for the file request responder: serial rx/tx bytes,
// file table lookup, memory port and status strobes.
interface file_responder_if #(
  parameter int IntSize = 8
);
  logic [IntSize-1:0] rxdata;
  logic               rxdata_rdy;
  logic [IntSize-1:0] txdata;
  logic               txdata_en;
  logic               tx_busy;
  logic [15:0]        file_index;
  logic [15:0]        file_base;
  logic [15:0]        file_len;
  logic [15:0]        mem_addr;
  logic [IntSize-1:0] mem_wdata;
  logic               mem_we;
  logic [IntSize-1:0] mem_rdata;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output rxdata, rxdata_rdy, tx_busy,
    output file_base, file_len, mem_rdata,
    input  txdata, txdata_en, file_index,
    input  mem_addr, mem_wdata, mem_we,
    input  busy, done, err
  );

  modport slave (
    input  rxdata, rxdata_rdy, tx_busy,
    input  file_base, file_len, mem_rdata,
    output txdata, txdata_en, file_index,
    output mem_addr, mem_wdata, mem_we,
    output busy, done, err
  );
endinterface

// File: rtl/file_responder.sv
// Responder for the PE file request protocol: header, 16-bit file
// index, then a read stream to the transmitter or a write stream to memory.
module file_responder #(
  parameter logic [15:0] TIMEOUT = 16'd50000,
  parameter int          IntSize = 8
) (
  input logic             clk,
  input logic             reset,
  file_responder_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, IDX_HI, IDX_LO, LOOKUP, RD_FETCH,
    RD_SEND, RD_WAIT, WR_RECV, FINISH
  } state_t;

  localparam logic [IntSize-1:0] HdrRead  = IntSize'(8'h52);
  localparam logic [IntSize-1:0] HdrWrite = IntSize'(8'h57);

  state_t             state, state_n;
  logic               wr_mode, wr_mode_n;
  logic [15:0]        idx, idx_n;
  logic [15:0]        ptr, ptr_n;
  logic [15:0]        rem, rem_n;
  logic [15:0]        tmo, tmo_n;
  logic               first, first_n;
  logic [IntSize-1:0] txd, txd_n;
  logic               txen, txen_n;
  logic [15:0]        addr, addr_n;
  logic [IntSize-1:0] wdat, wdat_n;
  logic               we, we_n;
  logic               dn, dn_n;
  logic               er, er_n;
  logic               rdy;
  logic               expire;

  assign rdy    = bus.rxdata_rdy;
  // silence long enough that the next idle edge would hit TIMEOUT
  assign expire = !rdy && (tmo == TIMEOUT - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wr_mode <= 1'b0;
      idx     <= '0;
      ptr     <= '0;
      rem     <= '0;
      tmo     <= '0;
      first   <= 1'b0;
      txd     <= '0;
      txen    <= 1'b0;
      addr    <= '0;
      wdat    <= '0;
      we      <= 1'b0;
      dn      <= 1'b0;
      er      <= 1'b0;
    end else begin
      state   <= state_n;
      wr_mode <= wr_mode_n;
      idx     <= idx_n;
      ptr     <= ptr_n;
      rem     <= rem_n;
      tmo     <= tmo_n;
      first   <= first_n;
      txd     <= txd_n;
      txen    <= txen_n;
      addr    <= addr_n;
      wdat    <= wdat_n;
      we      <= we_n;
      dn      <= dn_n;
      er      <= er_n;
    end
  end

  always_comb begin
    state_n   = state;
    wr_mode_n = wr_mode;
    idx_n     = idx;
    ptr_n     = ptr;
    rem_n     = rem;
    tmo_n     = '0;
    first_n   = 1'b0;
    txd_n     = txd;
    txen_n    = 1'b0;
    addr_n    = addr;
    wdat_n    = wdat;
    we_n      = 1'b0;
    dn_n      = 1'b0;
    er_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (rdy && bus.rxdata == HdrRead) begin
          wr_mode_n = 1'b0;
          state_n   = IDX_HI;
        end else if (rdy && bus.rxdata == HdrWrite) begin
          wr_mode_n = 1'b1;
          state_n   = IDX_HI;
        end
      end
      IDX_HI, IDX_LO: begin
        tmo_n = rdy ? 16'd0 : tmo + 16'd1;
        if (rdy && state == IDX_HI) begin
          idx_n[15:8] = 8'(bus.rxdata);
          state_n     = IDX_LO;
        end else if (rdy) begin
          idx_n[7:0] = 8'(bus.rxdata);
          state_n    = LOOKUP;
        end else if (expire) begin
          er_n    = 1'b1;
          state_n = IDLE;
        end
      end
      LOOKUP: begin
        ptr_n = bus.file_base;
        rem_n = bus.file_len;
        if (bus.file_len == 16'd0) begin
          dn_n    = 1'b1;
          state_n = FINISH;
        end else if (wr_mode) begin
          state_n = WR_RECV;
        end else begin
          addr_n  = bus.file_base;
          state_n = RD_FETCH;
        end
      end
      RD_FETCH: state_n = RD_SEND;
      RD_SEND: begin
        if (!bus.tx_busy) begin
          txd_n   = bus.mem_rdata;
          txen_n  = 1'b1;
          ptr_n   = ptr + 16'd1;
          rem_n   = rem - 16'd1;
          first_n = 1'b1;
          state_n = RD_WAIT;
        end
      end
      // the transmitter raises busy only after seeing the strobe
      RD_WAIT: begin
        if (!first && !bus.tx_busy) begin
          if (rem != 16'd0) begin
            addr_n  = ptr;
            state_n = RD_FETCH;
          end else begin
            dn_n    = 1'b1;
            state_n = FINISH;
          end
        end
      end
      WR_RECV: begin
        tmo_n = rdy ? 16'd0 : tmo + 16'd1;
        if (rdy) begin
          we_n   = 1'b1;
          addr_n = ptr;
          wdat_n = bus.rxdata;
          ptr_n  = ptr + 16'd1;
          rem_n  = rem - 16'd1;
          if (rem == 16'd1) begin
            dn_n    = 1'b1;
            state_n = FINISH;
          end
        end else if (expire) begin
          er_n    = 1'b1;
          state_n = IDLE;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.txdata     = txd;
  assign bus.txdata_en  = txen;
  assign bus.file_index = idx;
  assign bus.mem_addr   = addr;
  assign bus.mem_wdata  = wdat;
  assign bus.mem_we     = we;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = dn;
  assign bus.err        = er;
endmodule
